// File: rtl/sr_excitation_encoder.sv
// sr_excitation_encoder: FIFO-fed encoder that turns target words into S/R excitation pulses for an SR flop bank.
// Optional build macro SR_ENC_FORCE_REFRESH_EN: every word drives absolute S=T, R=~T (no skipping).
module sr_excitation_encoder #(
   parameter int WIDTH = 12,
   parameter int HOLD  = 1,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] IN_DATA,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic [WIDTH-1:0] S,
   output logic [WIDTH-1:0] R,
   output logic             BUSY,
   output logic [WIDTH-1:0] SHADOW,
   output logic [15:0]      CHG_CNT
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(HOLD + 2);

   localparam logic [1:0] ST_INIT   = 2'd0;
   localparam logic [1:0] ST_IDLE   = 2'd1;
   localparam logic [1:0] ST_DRIVE  = 2'd2;
   localparam logic [1:0] ST_SETTLE = 2'd3;

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
   localparam logic [CW-1:0] HOLD_END  = CW'(HOLD);
   localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             run;
   logic             full, empty, push, pop;
   logic [1:0]       state;
   logic [CW-1:0]    hold_cnt;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] head, set_next, rst_next;

   assign full     = (count == FIFO_FULL);
   assign empty    = (count == '0);
   assign IN_READY = run & ~full;
   assign push     = IN_VALID & IN_READY;
   assign pop      = (state == ST_IDLE) & ~empty;
   assign head     = mem[rd_ptr];
   assign BUSY     = (state != ST_IDLE) | ~empty;

`ifdef SR_ENC_FORCE_REFRESH_EN
   assign set_next = head;
   assign rst_next = ~head;
`else
   assign set_next = head & ~SHADOW;
   assign rst_next = ~head & SHADOW;
`endif

   // NOTE: FIFO storage has no reset; count and pointers alone decide which entries are valid.
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= IN_DATA;
   end

   // Holds IN_READY low while reset is asserted without a combinational path from RST_N.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) run <= 1'b0;
      else        run <= 1'b1;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= ST_INIT;
         hold_cnt <= '0;
         S        <= '0;
         R        <= '0;
         SHADOW   <= '0;
         target   <= '0;
         CHG_CNT  <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               // Clear the whole bank so it matches the zeroed SHADOW.
               if (hold_cnt == HOLD_END) begin
                  R        <= '0;
                  hold_cnt <= '0;
                  state    <= ST_SETTLE;
               end else begin
                  R        <= '1;
                  hold_cnt <= hold_cnt + CW'(1);
               end
            end
            ST_IDLE: begin
               if (pop) begin
                  target <= head;
                  if ((set_next | rst_next) != '0) begin
                     S        <= set_next;
                     R        <= rst_next;
                     hold_cnt <= '0;
                     state    <= ST_DRIVE;
                     if (CHG_CNT != 16'hFFFF) CHG_CNT <= CHG_CNT + 16'd1;
                  end
               end
            end
            ST_DRIVE: begin
               if (hold_cnt == HOLD_LAST) begin
                  SHADOW   <= target;
                  S        <= '0;
                  R        <= '0;
                  hold_cnt <= '0;
                  state    <= ST_SETTLE;
               end else begin
                  hold_cnt <= hold_cnt + CW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sr_excitation_encoder.sv
// Directed and random bench for sr_excitation_encoder: one HOLD=1 instance and one HOLD=3 instance.
module tb_sr_excitation_encoder;
   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

`ifdef SR_ENC_FORCE_REFRESH_EN
   localparam bit          REFRESH = 1'b1;
   localparam logic [23:0] EXP_A   = {12'hF0F, 12'h0F0};
   localparam logic [23:0] EXP_B   = {12'h0FF, 12'hF00};
   localparam logic [23:0] EXP_C   = {12'h0FF, 12'hF00};
   localparam logic [15:0] CNT_C   = 16'd3;
`else
   localparam bit          REFRESH = 1'b0;
   localparam logic [23:0] EXP_A   = {12'hF0F, 12'h000};
   localparam logic [23:0] EXP_B   = {12'h0F0, 12'hF00};
   localparam logic [23:0] EXP_C   = {12'h000, 12'h000};
   localparam logic [15:0] CNT_C   = 16'd2;
`endif

   logic        rst1_n, d1_valid, rdy1, busy1;
   logic [11:0] d1_data, s1, r1, sh1;
   logic [15:0] cnt1;
   logic        rst3_n, d3_valid, rdy3, busy3;
   logic [11:0] d3_data, s3, r3, sh3;
   logic [15:0] cnt3;

   sr_excitation_encoder #(.WIDTH(12), .HOLD(1), .DEPTH(4)) u1 (
      .CLK(CLK), .RST_N(rst1_n), .IN_DATA(d1_data), .IN_VALID(d1_valid), .IN_READY(rdy1),
      .S(s1), .R(r1), .BUSY(busy1), .SHADOW(sh1), .CHG_CNT(cnt1));

   sr_excitation_encoder #(.WIDTH(12), .HOLD(3), .DEPTH(4)) u3 (
      .CLK(CLK), .RST_N(rst3_n), .IN_DATA(d3_data), .IN_VALID(d3_valid), .IN_READY(rdy3),
      .S(s3), .R(r3), .BUSY(busy3), .SHADOW(sh3), .CHG_CNT(cnt3));

   // Behavioural SR flop bank driven by the HOLD=1 instance.
   logic [11:0] bank1 = 12'hA5A;
   always @(posedge CLK) bank1 <= (bank1 & ~r1) | s1;

   function automatic logic [23:0] enc(input logic [11:0] t, input logic [11:0] sh);
      if (REFRESH) return {t, ~t};
      return {t & ~sh, ~t & sh};
   endfunction

   task automatic push1(input logic [11:0] w);
      d1_valid = 1'b1;
      d1_data  = w;
      @(negedge CLK);
      d1_valid = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_reset();
      rst1_n = 1'b0; rst3_n = 1'b0;
      d1_valid = 1'b0; d1_data = '0; d3_valid = 1'b0; d3_data = '0;
      @(negedge CLK); @(negedge CLK);
      checks++;
      if ({s1, r1, sh1, cnt1, rdy1} !== 53'd0) begin
         errors++; $display("FAIL reset_state: got S=%h R=%h SH=%h CNT=%0d RDY=%b want all zero", s1, r1, sh1, cnt1, rdy1);
      end
      rst1_n = 1'b1;
      @(negedge CLK);
      checks++;
      if ({s1, r1, rdy1} !== {12'h000, 12'hFFF, 1'b1}) begin
         errors++; $display("FAIL init_drive: got S=%h R=%h RDY=%b want S=000 R=fff RDY=1", s1, r1, rdy1);
      end
      @(negedge CLK);
      checks++;
      if ({s1, r1, busy1} !== {24'h0, 1'b1}) begin
         errors++; $display("FAIL init_settle: got S=%h R=%h BUSY=%b want 0 0 1", s1, r1, busy1);
      end
      @(negedge CLK);
      checks++;
      if ({s1, r1, sh1, cnt1, busy1, rdy1} !== {36'h0, 16'd0, 1'b0, 1'b1}) begin
         errors++; $display("FAIL init_idle: got S=%h R=%h SH=%h CNT=%0d BUSY=%b RDY=%b", s1, r1, sh1, cnt1, busy1, rdy1);
      end
   endtask

   task automatic test_diff_encode();
      push1(12'hF0F);
      checks++;
      if ({s1, r1} !== EXP_A) begin
         errors++; $display("FAIL first_word: got S=%h R=%h want %h", s1, r1, EXP_A);
      end
      @(negedge CLK);
      checks++;
      if ({s1, r1, sh1, cnt1, busy1} !== {24'h0, 12'hF0F, 16'd1, 1'b1}) begin
         errors++; $display("FAIL first_settle: got S=%h R=%h SH=%h CNT=%0d BUSY=%b want 0 0 f0f 1 1", s1, r1, sh1, cnt1, busy1);
      end
      @(negedge CLK);
      checks++;
      if (busy1 !== 1'b0) begin
         errors++; $display("FAIL first_idle: got BUSY=%b want 0", busy1);
      end
      push1(12'h0FF);
      checks++;
      if ({s1, r1} !== EXP_B) begin
         errors++; $display("FAIL second_word: got S=%h R=%h want %h", s1, r1, EXP_B);
      end
      @(negedge CLK); @(negedge CLK);
      checks++;
      if ({sh1, cnt1} !== {12'h0FF, 16'd2}) begin
         errors++; $display("FAIL second_state: got SH=%h CNT=%0d want 0ff 2", sh1, cnt1);
      end
      push1(12'h0FF);
      checks++;
      if ({s1, r1} !== EXP_C) begin
         errors++; $display("FAIL repeat_word: got S=%h R=%h want %h", s1, r1, EXP_C);
      end
      @(negedge CLK); @(negedge CLK);
      checks++;
      if ({sh1, cnt1, busy1} !== {12'h0FF, CNT_C, 1'b0}) begin
         errors++; $display("FAIL repeat_state: got SH=%h CNT=%0d BUSY=%b want 0ff %0d 0", sh1, cnt1, busy1, CNT_C);
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] w [6];
      logic [11:0] sh_m;
      logic [23:0] cur_exp;
      int idx, drv, run_len, last_start, first_low;
      bit pend, act, prev_act;
      w = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'hF00};
      rst3_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         checks++;
         if ({s3, r3} !== {12'h000, 12'hFFF}) begin
            errors++; $display("FAIL init3_drive%0d: got S=%h R=%h want 000 fff", i, s3, r3);
         end
      end
      @(negedge CLK); @(negedge CLK);
      checks++;
      if ({s3, r3, busy3} !== 25'd0) begin
         errors++; $display("FAIL init3_idle: got S=%h R=%h BUSY=%b want 0 0 0", s3, r3, busy3);
      end
      idx = 0; drv = 0; run_len = 0; last_start = 0; first_low = -1;
      pend = 1'b0; prev_act = 1'b0; sh_m = '0; cur_exp = '0;
      for (int c = 0; c < 45; c++) begin
         @(negedge CLK);
         if (pend) idx++;
         act = ((s3 | r3) != '0);
         if (act && !prev_act) begin
            checks++;
            if (drv >= 6) begin
               errors++; $display("FAIL b2b_extra_drive: got drive %0d want at most 6", drv + 1);
               cur_exp = 'x;
            end else begin
               cur_exp = enc(w[drv], sh_m);
               sh_m    = w[drv];
            end
            if (drv > 0) begin
               checks++;
               if (c - last_start != 5) begin
                  errors++; $display("FAIL b2b_period: got %0d cycles want 5 (drive %0d)", c - last_start, drv);
               end
            end
            last_start = c; drv++; run_len = 0;
         end
         if (act) begin
            run_len++;
            checks++;
            if ({s3, r3} !== cur_exp) begin
               errors++; $display("FAIL b2b_sr: got S=%h R=%h want %h (drive %0d)", s3, r3, cur_exp, drv);
            end
         end
         if (!act && prev_act) begin
            checks++;
            if (run_len != 3) begin
               errors++; $display("FAIL b2b_hold: got %0d cycles want 3 (drive %0d)", run_len, drv);
            end
         end
         prev_act = act;
         if (!rdy3 && first_low < 0) first_low = idx;
         if (idx < 6) begin
            d3_valid = 1'b1; d3_data = w[idx]; pend = rdy3;
         end else begin
            d3_valid = 1'b0; pend = 1'b0;
         end
      end
      checks++;
      if (first_low != 5) begin
         errors++; $display("FAIL b2b_ready_drop: got drop after %0d accepted want 5", first_low);
      end
      checks++;
      if (drv != 6 || idx != 6) begin
         errors++; $display("FAIL b2b_count: got drives=%0d accepted=%0d want 6 6", drv, idx);
      end
      checks++;
      if ({sh3, cnt3, busy3} !== {12'hF00, 16'd6, 1'b0}) begin
         errors++; $display("FAIL b2b_final: got SH=%h CNT=%0d BUSY=%b want f00 6 0", sh3, cnt3, busy3);
      end
   endtask

   task automatic test_reset_mid_drive();
      logic [23:0] exp_sr;
      exp_sr = enc(12'h0F0, 12'hF00);
      d3_valid = 1'b1; d3_data = 12'h0F0;
      @(negedge CLK);
      d3_data = 12'h00F;
      @(negedge CLK);
      d3_valid = 1'b0;
      @(negedge CLK);
      checks++;
      if ({s3, r3} !== exp_sr) begin
         errors++; $display("FAIL mid_drive_pre: got S=%h R=%h want %h", s3, r3, exp_sr);
      end
      rst3_n = 1'b0;
      #1;
      checks++;
      if ({s3, r3, sh3, cnt3, rdy3, busy3} !== {36'h0, 16'd0, 1'b0, 1'b1}) begin
         errors++; $display("FAIL mid_drive_reset: got S=%h R=%h SH=%h CNT=%0d RDY=%b BUSY=%b", s3, r3, sh3, cnt3, rdy3, busy3);
      end
      @(negedge CLK);
      rst3_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         checks++;
         if ({s3, r3} !== {12'h000, 12'hFFF}) begin
            errors++; $display("FAIL reinit_drive%0d: got S=%h R=%h want 000 fff", i, s3, r3);
         end
      end
      @(negedge CLK); @(negedge CLK);
      // A surviving FIFO entry would show up as BUSY or a drive here.
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({s3, r3, cnt3, busy3, sh3} !== 53'd0) begin
            errors++; $display("FAIL reinit_idle%0d: got S=%h R=%h CNT=%0d BUSY=%b SH=%h want all 0", i, s3, r3, cnt3, busy3, sh3);
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_random_stream();
      logic [11:0] sh_m;
      int acc, exp_cnt, drives;
      bit pend, act, prev_act, done;
      rst1_n = 1'b0;
      @(negedge CLK);
      rst1_n = 1'b1;
      @(negedge CLK); @(negedge CLK); @(negedge CLK);
      acc = 0; exp_cnt = 0; drives = 0; sh_m = '0;
      pend = 1'b0; prev_act = 1'b0; done = 1'b0;
      d1_valid = 1'b0; d1_data = 12'($urandom);
      for (int c = 0; c < 20000 && !done; c++) begin
         @(negedge CLK);
         if (pend) begin
            acc++;
            if (REFRESH || d1_data != sh_m) exp_cnt++;
            sh_m = d1_data;
            if ($urandom_range(0, 2) != 0) d1_data = 12'($urandom);
         end
         act = ((s1 | r1) != '0);
         checks++;
         if ((s1 & r1) !== 12'h000) begin
            errors++; $display("FAIL rand_s_and_r: got S&R=%h want 000 at cycle %0d", s1 & r1, c);
         end
         if (!act) begin
            checks++;
            if (bank1 !== sh1) begin
               errors++; $display("FAIL rand_bank: got bank=%h want SHADOW=%h at cycle %0d", bank1, sh1, c);
            end
         end
         if (act && !prev_act) drives++;
         prev_act = act;
         if (acc < 1000) begin
            d1_valid = 1'($urandom_range(0, 1));
            pend = d1_valid && rdy1;
         end else begin
            d1_valid = 1'b0;
            pend = 1'b0;
            done = !busy1;
         end
      end
      checks++;
      if (!done) begin
         errors++; $display("FAIL rand_timeout: got %0d accepted BUSY=%b want 1000 and idle", acc, busy1);
      end
      checks++;
      if (cnt1 !== 16'(exp_cnt) || drives != exp_cnt) begin
         errors++; $display("FAIL rand_count: got CHG_CNT=%0d drives=%0d want %0d", cnt1, drives, exp_cnt);
      end
      checks++;
      if ({sh1, bank1} !== {sh_m, sh_m}) begin
         errors++; $display("FAIL rand_final: got SH=%h bank=%h want %h", sh1, bank1, sh_m);
      end
   endtask

   initial begin
      test_reset();
      test_diff_encode();
      test_back_to_back();
      test_reset_mid_drive();
      test_random_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
